// File: rtl/pc_unit.sv
// Program counter with trap/redirect priority select and an optional return-address stack.
// The return-address stack is built only when PC_UNIT_RAS_EN is defined.
module pc_unit #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080),
   parameter int unsigned      INC          = 4,
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PCupdate,
   input  logic             trap,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC_next_seq,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_ovf
);

   // PC is held XOR RESET_VECTOR so an all-zero power-up state reads as RESET_VECTOR.
   logic [WIDTH-1:0] pc_enc;
   logic [WIDTH-1:0] pc_nxt;
   logic             ret_take;
   logic [WIDTH-1:0] ret_addr;

   assign PC          = pc_enc ^ RESET_VECTOR;
   assign PC_next_seq = PC + WIDTH'(INC);

`ifdef PC_UNIT_RAS_EN
   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] stack [RAS_DEPTH];
   logic [PW-1:0]    tp;
   logic [CW-1:0]    count;
   logic             ovf;
   logic             push;

   assign ras_empty = (count == '0);
   assign ras_full  = (count == CW'(RAS_DEPTH));
   assign ras_ovf   = ovf;
   assign push      = PCupdate && !trap && redirect && call;
   assign ret_take  = PCupdate && !trap && !redirect && ret && !ras_empty;
   assign ret_addr  = stack[tp - PW'(1)];

   // tp is the next write slot; when full it already points at the oldest entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         tp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (push) begin
         tp <= tp + PW'(1);
         if (ras_full) ovf   <= 1'b1;
         else          count <= count + CW'(1);
      end else if (ret_take) begin
         tp    <= tp - PW'(1);
         count <= count - CW'(1);
      end
   end

   // Stack contents carry no reset.
   always_ff @(posedge clk) begin
      if (!reset && push) stack[tp] <= PC_next_seq;
   end
`else
   logic unused_ras;

   assign unused_ras = ^{call, ret};
   assign ras_empty  = 1'b1;
   assign ras_full   = 1'b0;
   assign ras_ovf    = 1'b0;
   assign ret_take   = 1'b0;
   assign ret_addr   = '0;
`endif

   always_comb begin
      pc_nxt = PC_next_seq;
      if (trap)          pc_nxt = TRAP_VECTOR;
      else if (redirect) pc_nxt = redirect_target;
      else if (ret_take) pc_nxt = ret_addr;
   end

   always_ff @(posedge clk) begin
      if (reset)         pc_enc <= '0;
      else if (PCupdate) pc_enc <= pc_nxt ^ RESET_VECTOR;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_unit;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RV    = 32'h0;
   localparam logic [31:0] TV    = 32'h80;
`ifdef PC_UNIT_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1, PCupdate = 1'b0, trap = 1'b0, redirect = 1'b0, call = 1'b0, ret = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] PC, PC_next_seq;
   logic        ras_empty, ras_full, ras_ovf;

   logic        reset8 = 1'b1, upd8 = 1'b0, redirect8 = 1'b0, zero8 = 1'b0;
   logic [7:0]  target8 = '0;
   logic [7:0]  PC8, nseq8;
   logic        empty8, full8, ovf8;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   bit          m_ovf;
   bit          known = 1'b0;

   pc_unit dut (
      .clk(clk), .reset(reset), .PCupdate(PCupdate), .trap(trap), .redirect(redirect),
      .redirect_target(redirect_target), .call(call), .ret(ret), .PC(PC),
      .PC_next_seq(PC_next_seq), .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf)
   );

   pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80)) dut8 (
      .clk(clk), .reset(reset8), .PCupdate(upd8), .trap(zero8), .redirect(redirect8),
      .redirect_target(target8), .call(zero8), .ret(zero8), .PC(PC8),
      .PC_next_seq(nseq8), .ras_empty(empty8), .ras_full(full8), .ras_ovf(ovf8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the model, compare the registered results after the edge.
   task automatic cycle(input bit rst, input bit upd, input bit tr, input bit rd,
                        input logic [31:0] tgt, input bit cl, input bit rt);
      logic [31:0] seq;
      reset = rst; PCupdate = upd; trap = tr; redirect = rd;
      redirect_target = tgt; call = cl; ret = rt;
      #1;
      if (known) chk("next_seq", PC_next_seq, m_pc + 32'd4);
      seq = m_pc + 32'd4;
      if (rst) begin
         m_pc = RV; m_q.delete(); m_ovf = 1'b0; known = 1'b1;
      end else if (upd) begin
         if (tr) m_pc = TV;
         else if (rd) begin
            if (RAS_EN && cl) begin
               if (m_q.size() == DEPTH) begin
                  void'(m_q.pop_front());
                  m_ovf = 1'b1;
               end
               m_q.push_back(seq);
            end
            m_pc = tgt;
         end else if (RAS_EN && rt && m_q.size() > 0) m_pc = m_q.pop_back();
         else m_pc = seq;
      end
      @(posedge clk); #1;
      chk("pc", PC, m_pc);
      chk("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
      chk("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
      chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
   endtask

   task automatic cycle8(input bit rst, input bit upd, input bit rd, input logic [7:0] tgt);
      reset8 = rst; upd8 = upd; redirect8 = rd; target8 = tgt;
      @(posedge clk); #1;
   endtask

   initial begin
      #1;
      // basic sequencing and stall
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("reset_pc", PC, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 0, 0, 0, 0);
         chk("seq_pc", PC, 32'(4 * (i + 1)));
      end
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 1, 1, 32'h400, 1, 1);
         chk("stall_pc", PC, 32'd12);
      end
      // call then return
      cycle(0, 1, 0, 1, 32'h10, 0, 0);
      cycle(0, 1, 0, 1, 32'h100, 1, 0);
      chk("call_pc", PC, 32'h100);
      cycle(0, 1, 0, 0, 0, 0, 1);
      // trap beats redirect and ret with a non-empty stack
      cycle(0, 1, 0, 1, 32'h200, 1, 0);
      cycle(0, 1, 1, 1, 32'h300, 1, 1);
      chk("trap_pc", PC, 32'h80);
      // ret while redirect is asserted is ignored
      cycle(0, 1, 0, 1, 32'h340, 0, 1);
      // overflow: five calls into four entries, then five returns
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, 32'h2000 + 32'(i) * 32'h100, 1, 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0, 1);
      // call without redirect is ignored
      cycle(0, 1, 0, 0, 32'h500, 1, 0);
      // reset on a call discards it, and beats a stalled update
      cycle(0, 1, 0, 1, 32'h600, 1, 0);
      cycle(1, 1, 0, 1, 32'h700, 1, 0);
      chk("reset_call_pc", PC, 32'h0);
      cycle(0, 1, 0, 1, 32'h800, 1, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
               $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 2) == 0));
      end
      // 8-bit wrap-around
      cycle8(1, 0, 0, 8'h00);
      chk("w8_reset", 32'(PC8), 32'h00);
      cycle8(0, 1, 1, 8'hFC);
      chk("w8_redirect", 32'(PC8), 32'hFC);
      chk("w8_next_seq", 32'(nseq8), 32'h00);
      cycle8(0, 1, 0, 8'h00);
      chk("w8_wrap", 32'(PC8), 32'h00);
      chk("w8_empty", 32'(empty8), 32'h1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0080: PC value loaded on trap.
REQ-004 Parameter INC, default 4: sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4: return-address stack entries; a power of two, at least 2.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 PCupdate  input  1  update enable; low holds all state (stall).
REQ-009 trap  input  1  load TRAP_VECTOR.
REQ-010 redirect  input  1  load redirect_target (branch or jump taken).
REQ-011 redirect_target  input  WIDTH  redirect destination.
REQ-012 call  input  1  qualifies redirect as a call; pushes the return address.
REQ-013 ret  input  1  return; pops the RAS top into PC.
REQ-014 PC  output  WIDTH  current PC, registered.
REQ-015 PC_next_seq  output  WIDTH  PC+INC, combinational.
REQ-016 ras_empty  output  1  RAS holds no entries.
REQ-017 ras_full  output  1  RAS holds RAS_DEPTH entries.
REQ-018 ras_ovf  output  1  sticky flag: a push occurred while the RAS was full.

Function
REQ-019 PC_next_seq shall equal (PC+INC) mod 2^WIDTH; wrap-around is silent.
REQ-020 With PCupdate low, PC, the RAS and ras_ovf shall hold regardless of the other inputs.
REQ-021 With PCupdate high, the next PC shall be selected by strict priority:
- trap: TRAP_VECTOR
- redirect: redirect_target
- ret with RAS non-empty: RAS top
- otherwise: PC_next_seq
REQ-022 Each PC update shall take effect one cycle after the qualifying edge; no bypass path.
REQ-023 Trap shall perform no RAS operation and shall ignore call and ret in the same cycle.
REQ-024 redirect&call without trap shall push PC_next_seq in the same cycle as the redirect.
REQ-025 call without redirect shall be ignored.
REQ-026 ret shall be ignored whenever trap or redirect is asserted.
REQ-027 ret with the RAS empty shall load PC_next_seq and perform no pop.
REQ-028 A push while full shall overwrite the oldest entry (circular), keep the count at RAS_DEPTH, and set ras_ovf.
REQ-029 ras_ovf shall clear only on reset.
REQ-030 RAS occupancy shall be tracked by a count from 0 to RAS_DEPTH.
REQ-031 ras_empty shall be (count==0); ras_full shall be (count==RAS_DEPTH); both are registered-state derived.
REQ-032 The latest push shall be the first pop (LIFO).

Reset
REQ-033 reset shall take priority over PCupdate and all other inputs.
REQ-034 On reset: PC=RESET_VECTOR, count=0, ras_empty=1, ras_full=0, ras_ovf=0.
REQ-035 RAS entry contents need not be cleared on reset.
REQ-036 A reset asserted mid-call or mid-return shall discard that operation entirely.
REQ-037 From power-up, before the first reset, PC shall initialise to RESET_VECTOR.

Configuration
REQ-038 Macro PC_UNIT_RAS_EN defined: the RAS, ret, call and ras_ovf behave as specified above.
REQ-039 Macro PC_UNIT_RAS_EN undefined: no RAS storage is built.
- call and ret are ignored (ret follows the sequential path).
- ras_empty is tied to 1; ras_full and ras_ovf are tied to 0.
- Trap, redirect, stall and sequential behaviour are unchanged.

Verification
REQ-040 Reset, then PCupdate=1 for 3 cycles -> PC=0,4,8,12; PCupdate=0 for 2 cycles -> PC holds 12.
REQ-041 At PC=0x10, redirect=1, call=1, target=0x100 -> PC=0x100, count=1; then ret=1 -> PC=0x14, ras_empty=1.
REQ-042 trap=1, redirect=1 and ret=1 together with RAS non-empty -> PC=0x80, count unchanged.
REQ-043 5 calls with RAS_DEPTH=4 (return addresses A1..A5) -> ras_full=1, ras_ovf=1; 4 rets -> PC=A5,A4,A3,A2; a 5th ret -> PC_next_seq.
REQ-044 WIDTH=8 with PC=0xFC, sequential update -> PC=0x00.
REQ-045 reset asserted in the same cycle as call&redirect -> PC=RESET_VECTOR, ras_empty=1, ras_ovf=0.
